// File: rtl/shift_reg_led_multi.sv
// Multi-mode LED shift register: shift left/right, rotate left, or bounce a
// pattern back and forth, with parallel load, serial out and a WIDTH-step pulse.
module shift_reg_led_multi #(
  parameter int unsigned            WIDTH   = 8,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_in,
  input  logic             d_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] par_in,
  input  logic [1:0]       mode_in,
  output logic [WIDTH-1:0] led,
  output logic             d_out,
  output logic             full_out
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    MODE_SHL    = 2'b00,
    MODE_SHR    = 2'b01,
    MODE_ROL    = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  logic [WIDTH-1:0] r_led;
  logic             r_d_out;
  logic             r_full;
  logic [CW-1:0]    r_cnt;
  dir_t             r_dir;

  logic [WIDTH-1:0] w_next_led;
  logic             w_next_dout;
  dir_t             w_next_dir;
  logic             w_cnt_wrap;
  mode_t            w_mode;

  assign w_mode     = mode_t'(mode_in);
  assign w_cnt_wrap = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next_led  = r_led;
    w_next_dout = r_d_out;
    w_next_dir  = r_dir;
    unique case (w_mode)
      MODE_SHL: begin
        w_next_led  = {r_led[WIDTH-2:0], d_in};
        w_next_dout = r_led[WIDTH-1];
      end
      MODE_SHR: begin
        w_next_led  = {d_in, r_led[WIDTH-1:1]};
        w_next_dout = r_led[0];
      end
      MODE_ROL: begin
        w_next_led  = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
        w_next_dout = r_led[WIDTH-1];
      end
      MODE_BOUNCE: begin
        // Direction flips once the lit bit reaches the end it was travelling toward.
        if (r_dir == DIR_LEFT) begin
          w_next_led  = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
          w_next_dout = r_led[WIDTH-1];
          if (r_led[WIDTH-2]) w_next_dir = DIR_RIGHT;
        end else begin
          w_next_led  = {r_led[0], r_led[WIDTH-1:1]};
          w_next_dout = r_led[0];
          if (r_led[1]) w_next_dir = DIR_LEFT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led   <= RST_VAL;
      r_d_out <= 1'b0;
      r_full  <= 1'b0;
      r_cnt   <= '0;
      r_dir   <= DIR_LEFT;
    end else if (load_in) begin
      r_led   <= par_in;
      r_d_out <= 1'b0;
      r_full  <= 1'b0;
      r_cnt   <= '0;
      r_dir   <= DIR_LEFT;
    end else if (ce_in) begin
      r_led   <= w_next_led;
      r_d_out <= w_next_dout;
      r_dir   <= w_next_dir;
      r_full  <= w_cnt_wrap;
      r_cnt   <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
    end else begin
      r_full  <= 1'b0;
    end
  end

  assign led      = r_led;
  assign d_out    = r_d_out;
  assign full_out = r_full;

endmodule

// File: tb/tb_shift_reg_led_multi.sv
// Scoreboard bench for shift_reg_led_multi (WIDTH=8, RST_VAL=0): stimulus pushes
// hand-computed expectations, a monitor pops and compares one per clock.
module tb_shift_reg_led_multi;

  typedef struct {
    logic [7:0] led;
    logic       d;
    logic       f;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ce_in;
  logic       d_in;
  logic       load_in;
  logic [7:0] par_in;
  logic [1:0] mode_in;
  logic [7:0] led;
  logic       d_out;
  logic       full_out;

  exp_t sb[$];
  int   total;
  int   bad;

  shift_reg_led_multi #(
    .WIDTH  (8),
    .RST_VAL(8'h00)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce_in   (ce_in),
    .d_in    (d_in),
    .load_in (load_in),
    .par_in  (par_in),
    .mode_in (mode_in),
    .led     (led),
    .d_out   (d_out),
    .full_out(full_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] eled, input logic ed, input logic ef);
    total++;
    if (led !== eled || d_out !== ed || full_out !== ef) begin
      bad++;
      $display("FAIL %s: got led=%02h d_out=%b full_out=%b, expected led=%02h d_out=%b full_out=%b",
               nm, led, d_out, full_out, eled, ed, ef);
    end
  endtask

  // Drive one clock's inputs and queue the state expected after the next edge.
  task automatic cyc(input logic ld, input logic ce, input logic [1:0] md, input logic d,
                     input logic [7:0] par, input logic [7:0] eled, input logic ed,
                     input logic ef, input string nm);
    exp_t e;
    load_in = ld;
    ce_in   = ce;
    mode_in = md;
    d_in    = d;
    par_in  = par;
    e.led = eled; e.d = ed; e.f = ef; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, e.led, e.d, e.f);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] v;
    total = 0;
    bad   = 0;
    rst     = 1'b0;
    ce_in   = 1'b1;
    load_in = 1'b1;
    d_in    = 1'b1;
    par_in  = 8'hAA;
    mode_in = 2'b11;

    // Inputs active while in reset must be ignored.
    repeat (4) begin
      @(negedge clk);
      #1 check("rst_hold", 8'h00, 1'b0, 1'b0);
    end
    rst = 1'b1;

    // First edge after release performs the step.
    cyc(0, 1, 2'b00, 1, 8'h00, 8'h01, 0, 0, "shl1");
    cyc(0, 1, 2'b00, 1, 8'h00, 8'h03, 0, 0, "shl2");
    cyc(0, 1, 2'b00, 1, 8'h00, 8'h07, 0, 0, "shl3");

    cyc(1, 0, 2'b00, 0, 8'h81, 8'h81, 0, 0, "ld81");
    cyc(0, 1, 2'b10, 0, 8'h00, 8'h03, 1, 0, "rol1");
    cyc(0, 0, 2'b11, 1, 8'hFF, 8'h03, 1, 0, "hold");
    cyc(1, 1, 2'b10, 1, 8'h55, 8'h55, 0, 0, "ld_over_ce");

    cyc(1, 0, 2'b01, 0, 8'h80, 8'h80, 0, 0, "ld80");
    for (int i = 1; i <= 8; i++) begin
      v = 8'h80 >> i;
      cyc(0, 1, 2'b01, 0, 8'h00, v, (i == 8), (i == 8), "shr");
    end
    cyc(0, 0, 2'b01, 0, 8'h00, 8'h00, 1, 0, "full_once");

    cyc(1, 0, 2'b11, 0, 8'h01, 8'h01, 0, 0, "ld01");
    for (int i = 1; i <= 7; i++) begin
      v = 8'h01 << i;
      cyc(0, 1, 2'b11, 0, 8'h00, v, 0, 0, "bounce_left");
    end
    cyc(0, 1, 2'b11, 0, 8'h00, 8'h40, 0, 1, "bounce_turn_right");
    for (int i = 1; i <= 6; i++) begin
      v = 8'h40 >> i;
      cyc(0, 1, 2'b11, 0, 8'h00, v, 0, 0, "bounce_right");
    end
    cyc(0, 1, 2'b11, 0, 8'h00, 8'h02, 0, 0, "bounce_turn_left");
    cyc(0, 1, 2'b11, 0, 8'h00, 8'h04, 0, 1, "bounce_wrap16");
    cyc(0, 1, 2'b11, 0, 8'h00, 8'h08, 0, 0, "bounce_more1");
    cyc(0, 1, 2'b11, 0, 8'h00, 8'h10, 0, 0, "bounce_more2");

    // Asynchronous reset between edges with the counter mid-count.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst", 8'h00, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      #1 check("rst_held", 8'h00, 1'b0, 1'b0);
    end
    rst = 1'b1;

    // Counter restarted from zero: wrap lands on the 8th step after release.
    for (int i = 1; i <= 8; i++) begin
      v = 8'hFF >> (8 - i);
      cyc(0, 1, 2'b00, 1, 8'h00, v, 0, (i == 8), "post_rst_shl");
    end
    cyc(1, 0, 2'b10, 0, 8'h01, 8'h01, 0, 0, "ld01_post");
    cyc(0, 1, 2'b10, 0, 8'h00, 8'h02, 0, 0, "rol_post");
    ce_in = 1'b0;
    load_in = 1'b0;

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
